v_speed_ticker: RTL

Consumer of the debounced soft-drop key level. Generates the one-cycle fall_tick pulse that steps the active Tetris piece down one row. Without soft-drop, ticks come at a level-dependent gravity period. While soft-drop is held, the block issues one immediate tick, waits a repeat delay, then ticks at the fast period.

---
 rtl/v_speed_pkg.sv | 12 +
 rtl/v_speed_period.sv | 27 ++
 rtl/v_speed_ticker.sv | 130 +++++++++++++
 3 files changed

// File: rtl/v_speed_pkg.sv
// rtl/v_speed_pkg.sv - shared state encoding and widths for the fall-speed ticker
package v_speed_pkg;

    localparam int LEVEL_W = 4;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

endpackage

// File: rtl/v_speed_period.sv
// rtl/v_speed_period.sv - level-dependent gravity period with soft-drop floor clamp
module v_speed_period
    import v_speed_pkg::*;
#(
    parameter int NORM_PERIOD = 25_000_000,
    parameter int LEVEL_STEP  = 1_500_000,
    parameter int FAST_PERIOD = 2_500_000,
    parameter int CNT_W       = 25
) (
    input  logic [LEVEL_W-1:0] i_level,
    output logic [CNT_W-1:0]   o_gp
);

    localparam int GW = CNT_W + 4;
    localparam logic [GW-1:0] NORM_W = GW'(NORM_PERIOD);
    localparam logic [GW-1:0] STEP_W = GW'(LEVEL_STEP);
    localparam logic [GW-1:0] FAST_W = GW'(FAST_PERIOD);

    logic [GW-1:0] w_dec;
    logic [GW-1:0] w_gp;

    // Clamp test is done on the decrement so a large level never wraps below zero.
    assign w_dec = GW'(i_level) * STEP_W;
    assign w_gp  = (w_dec > (NORM_W - FAST_W)) ? FAST_W : (NORM_W - w_dec);
    assign o_gp  = w_gp[CNT_W-1:0];

endmodule

// File: rtl/v_speed_ticker.sv
// rtl/v_speed_ticker.sv - gravity / soft-drop fall_tick generator
module v_speed_ticker
    import v_speed_pkg::*;
#(
    parameter int NORM_PERIOD  = 25_000_000,
    parameter int LEVEL_STEP   = 1_500_000,
    parameter int FAST_PERIOD  = 2_500_000,
    parameter int REPEAT_DELAY = 10_000_000,
    parameter int CNT_W        = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_db_n,
    input  logic [LEVEL_W-1:0] level,
    input  logic               pause,
    input  logic               restart,
    output logic               fall_tick,
    output logic               fast_mode
);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] FP_LAST = CNT_W'(FAST_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_gp;
    logic             r_key_d;
    logic             r_tick;
    logic             r_fast;
    logic             w_tick_nxt;
    logic             w_press;
    logic             w_release;
    logic             w_norm_term;

    v_speed_period #(
        .NORM_PERIOD(NORM_PERIOD),
        .LEVEL_STEP (LEVEL_STEP),
        .FAST_PERIOD(FAST_PERIOD),
        .CNT_W      (CNT_W)
    ) u_period (
        .i_level(level),
        .o_gp   (w_gp)
    );

    assign w_press     = r_key_d & ~key_db_n;
    assign w_release   = ~r_key_d & key_db_n;
    assign w_cnt_inc   = r_cnt + ONE;
    // >= rather than == so a level change that shortens the period below cnt still fires.
    assign w_norm_term = (r_cnt >= (w_gp - ONE));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tick_nxt  = 1'b0;
        if (pause) begin
            if (w_press) begin
                w_state_nxt = DELAY;
                w_cnt_nxt   = '0;
            end else if (w_release) begin
                w_state_nxt = NORMAL;
                w_cnt_nxt   = '0;
            end
        end else if (w_press) begin
            w_state_nxt = DELAY;
            w_cnt_nxt   = '0;
            w_tick_nxt  = 1'b1;
        end else if (w_release) begin
            w_state_nxt = NORMAL;
            w_cnt_nxt   = '0;
        end else if (restart) begin
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                NORMAL: begin
                    if (w_norm_term) begin
                        w_cnt_nxt  = '0;
                        w_tick_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                DELAY: begin
                    if (r_cnt == RD_LAST) begin
                        w_state_nxt = REPEAT;
                        w_cnt_nxt   = '0;
                        w_tick_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                REPEAT: begin
                    if (r_cnt == FP_LAST) begin
                        w_cnt_nxt  = '0;
                        w_tick_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = NORMAL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= NORMAL;
            r_cnt   <= '0;
            r_key_d <= 1'b1;
            r_tick  <= 1'b0;
            r_fast  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_key_d <= key_db_n;
            r_tick  <= w_tick_nxt;
            r_fast  <= (w_state_nxt == REPEAT);
        end
    end

    assign fall_tick = r_tick;
    assign fast_mode = r_fast;

endmodule
